// File: rtl/tmds_pll_pkg.sv
// Shared definitions for the TMDS PLL sequencer.
//   pll_state_e      : sequencer states
//   MODE_MDIV/ODIV0/1: divider table for the four video clock modes
//   dyn_sel_encode() : divider value -> 7-bit PLL dynamic-select code
//   SYNC_STAGES      : depth of the PLL lock synchronizer
package tmds_pll_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_ASSERT_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } pll_state_e;

  localparam int SYNC_STAGES = 2;
  localparam int NUM_MODES   = 4;

  // VCO = 50 MHz * MDIV; serial clock = VCO / ODIV0; pixel clock = VCO / ODIV1.
  localparam int unsigned MODE_MDIV  [NUM_MODES] = '{26, 30, 20, 27};
  localparam int unsigned MODE_ODIV0 [NUM_MODES] = '{ 7,  4,  8,  5};
  localparam int unsigned MODE_ODIV1 [NUM_MODES] = '{35, 20, 40, 25};

  // The PLL dynamic-select inputs take a divider N as the 7-bit code 128 - N.
  function automatic logic [6:0] dyn_sel_encode(input int unsigned div);
    int unsigned code;
    code = 32'd128 - div;
    return code[6:0];
  endfunction

endpackage

// File: rtl/tmds_pll_ctrl_lock_sync.sv
// lock_sync: multi-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears the chain to 0
//   d     : asynchronous input
//   q     : synchronized output, STAGES cycles of latency
module lock_sync
  import tmds_pll_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: non-blocking assignments make each stage take the previous stage's
  // old value, which is what builds the multi-cycle chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/tmds_pll_ctrl.sv
// tmds_pll_ctrl: programs the TMDS PLL dynamic dividers for one of four video
// modes, pulses PLL reset, waits for a debounced lock and only then releases
// the downstream reset. Handles lock timeout with bounded retry, loss of lock
// and run-time mode changes.
//   clkin          : 50 MHz free-running reference clock
//   rst_n          : asynchronous active-low reset
//   mode_req       : requested mode index, taken with mode_req_valid when ready
//   ready          : high in RUN or FAULT (a mode request will be accepted)
//   pll_lock       : raw PLL lock, asynchronous
//   pll_reset      : PLL reset, active high
//   pll_mdsel      : encoded feedback divider select
//   pll_odsel0     : encoded serial-clock output divider select
//   pll_odsel1     : encoded pixel-clock output divider select
//   out_rst_n      : downstream serializer/timing reset, active low
//   cur_mode       : mode currently programmed
//   locked / fault : high only in RUN / FAULT
//   retry_cnt      : lock attempts that timed out in the current sequence
module tmds_pll_ctrl
  import tmds_pll_pkg::*;
#(
  parameter int RST_CYCLES     = 50,
  parameter int STABLE_CYCLES  = 5000,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRY      = 3,
  parameter int DEFAULT_MODE   = 0
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic [1:0] mode_req,
  input  logic       mode_req_valid,
  output logic       ready,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [6:0] pll_mdsel,
  output logic [6:0] pll_odsel0,
  output logic [6:0] pll_odsel1,
  output logic       out_rst_n,
  output logic [1:0] cur_mode,
  output logic       locked,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam int MAX_A   = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CNT);
  localparam logic [1:0] DEF_MODE = 2'(DEFAULT_MODE);

  pll_state_e    state;
  logic [CW-1:0] cnt;
  logic          lock_s;
  logic          take_req;

  lock_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clkin),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // ready is only high in RUN and FAULT, the two states that accept requests.
  assign take_req = ready & mode_req_valid;

  // All outputs are registered and updated on the same edge as the state, so
  // they always describe the state the sequencer is currently in. The new
  // mode's selects are written on entry to LOAD, so they are already stable
  // while PLL reset is asserted.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      cnt        <= '0;
      pll_reset  <= 1'b1;
      out_rst_n  <= 1'b0;
      ready      <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      retry_cnt  <= '0;
      cur_mode   <= DEF_MODE;
      pll_mdsel  <= dyn_sel_encode(MODE_MDIV[DEF_MODE]);
      pll_odsel0 <= dyn_sel_encode(MODE_ODIV0[DEF_MODE]);
      pll_odsel1 <= dyn_sel_encode(MODE_ODIV1[DEF_MODE]);
    end else if (take_req) begin
      // A request beats a simultaneous loss of lock in RUN.
      state      <= ST_LOAD;
      cnt        <= '0;
      pll_reset  <= 1'b1;
      out_rst_n  <= 1'b0;
      ready      <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
      retry_cnt  <= '0;
      cur_mode   <= mode_req;
      pll_mdsel  <= dyn_sel_encode(MODE_MDIV[mode_req]);
      pll_odsel0 <= dyn_sel_encode(MODE_ODIV0[mode_req]);
      pll_odsel1 <= dyn_sel_encode(MODE_ODIV1[mode_req]);
    end else begin
      case (state)
        ST_LOAD: begin
          state <= ST_ASSERT_RST;
          cnt   <= '0;
        end

        ST_ASSERT_RST: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            state     <= ST_WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            cnt       <= '0;
            retry_cnt <= retry_cnt + 2'd1;
            if (int'(retry_cnt) + 1 < MAX_RETRY) begin
              state     <= ST_ASSERT_RST;
              pll_reset <= 1'b1;
            end else begin
              state <= ST_FAULT;
              fault <= 1'b1;
              ready <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // The WAIT_LOCK cycle that saw lock counts as the first stable cycle,
        // so STABLE itself needs STABLE_CYCLES-1 more high samples.
        ST_STABLE: begin
          if (!lock_s) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CW'(STABLE_CYCLES - 2)) begin
            state     <= ST_RUN;
            out_rst_n <= 1'b1;
            locked    <= 1'b1;
            ready     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state     <= ST_ASSERT_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            out_rst_n <= 1'b0;
            ready     <= 1'b0;
            locked    <= 1'b0;
            retry_cnt <= '0;
          end
        end

        ST_FAULT: ;  // sticky until a mode request

        default: begin
          state     <= ST_LOAD;
          cnt       <= '0;
          pll_reset <= 1'b1;
          out_rst_n <= 1'b0;
          ready     <= 1'b0;
          locked    <= 1'b0;
          fault     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_pll_ctrl.sv
// Self-checking bench for tmds_pll_ctrl. Timing expectations come from the
// sequencing rules as plain arithmetic (pulse widths, lock-to-release delay,
// timeout length); mode selects come from the bench's own divider table.
module tb_tmds_pll_ctrl;
  import tmds_pll_pkg::*;

  localparam int RST    = 8;
  localparam int STABLE = 40;
  localparam int TMO    = 200;
  localparam int RETRY  = 3;
  localparam int DEFM   = 0;
  localparam int BUDGET = 4 * TMO;
  localparam int SYNC_LAT = 2;

  localparam int P_RST   = 0;
  localparam int P_OUT   = 1;
  localparam int P_RETRY = 2;

  int unsigned ref_mdiv  [4] = '{26, 30, 20, 27};
  int unsigned ref_odiv0 [4] = '{ 7,  4,  8,  5};
  int unsigned ref_odiv1 [4] = '{35, 20, 40, 25};

  logic       clkin = 1'b0;
  logic       rst_n;
  logic [1:0] mode_req;
  logic       mode_req_valid;
  logic       pll_lock;
  logic       ready, pll_reset, out_rst_n, locked, fault;
  logic [6:0] pll_mdsel, pll_odsel0, pll_odsel1;
  logic [1:0] cur_mode, retry_cnt;

  int errors = 0;
  int checks = 0;

  tmds_pll_ctrl #(
    .RST_CYCLES     (RST),
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRY      (RETRY),
    .DEFAULT_MODE   (DEFM)
  ) dut (
    .clkin          (clkin),
    .rst_n          (rst_n),
    .mode_req       (mode_req),
    .mode_req_valid (mode_req_valid),
    .ready          (ready),
    .pll_lock       (pll_lock),
    .pll_reset      (pll_reset),
    .pll_mdsel      (pll_mdsel),
    .pll_odsel0     (pll_odsel0),
    .pll_odsel1     (pll_odsel1),
    .out_rst_n      (out_rst_n),
    .cur_mode       (cur_mode),
    .locked         (locked),
    .fault          (fault),
    .retry_cnt      (retry_cnt)
  );

  always #5 clkin = ~clkin;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  function automatic int probe(input int sel);
    case (sel)
      P_RST:   return int'(pll_reset);
      P_OUT:   return int'(out_rst_n);
      default: return int'(retry_cnt);
    endcase
  endfunction

  // Number of edges until the probed output reaches val (BUDGET if never).
  task automatic wait_until(input int sel, input int val, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (probe(sel) != val && n < BUDGET);
  endtask

  task automatic check_mode(input string tag, input int m);
    check({tag, "_cur_mode"}, cur_mode, m);
    check({tag, "_mdsel"},  pll_mdsel,  dyn_sel_encode(ref_mdiv[m]));
    check({tag, "_odsel0"}, pll_odsel0, dyn_sel_encode(ref_odiv0[m]));
    check({tag, "_odsel1"}, pll_odsel1, dyn_sel_encode(ref_odiv1[m]));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pll_reset"}, pll_reset, 1);
    check({tag, "_out_rst_n"}, out_rst_n, 0);
    check({tag, "_ready"},     ready,     0);
    check({tag, "_locked"},    locked,    0);
    check({tag, "_fault"},     fault,     0);
    check({tag, "_retry"},     retry_cnt, 0);
    check_mode(tag, DEFM);
  endtask

  // Issue a one-cycle request; a real PLL loses lock once it is re-programmed.
  task automatic request(input int m);
    mode_req       = 2'(m);
    mode_req_valid = 1'b1;
    pll_lock       = 1'b0;
    tick();
    mode_req_valid = 1'b0;
  endtask

  // From a point where pll_reset is high: expect the given remaining pulse
  // width, then lock after a random delay and expect release STABLE+2 later.
  task automatic relock(input string tag, input int rst_width);
    int n;
    int d;
    wait_until(P_RST, 0, n);
    check({tag, "_rst_width"}, n, rst_width);
    d = $urandom_range(3, 60);
    repeat (d) tick();
    pll_lock = 1'b1;
    wait_until(P_OUT, 1, n);
    check({tag, "_lock_to_release"}, n, STABLE + SYNC_LAT);
    check({tag, "_locked"}, locked, 1);
    check({tag, "_ready"},  ready,  1);
  endtask

  initial begin
    int n;
    int m;
    int g;
    int prev;

    rst_n          = 1'b0;
    mode_req       = '0;
    mode_req_valid = 1'b0;
    pll_lock       = 1'b0;

    // Reset state and first bring-up: LOAD cycle plus RST-cycle pulse.
    repeat (3) tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    relock("boot", RST + 1);
    check_mode("boot", DEFM);
    check("boot_retry", retry_cnt, 0);

    // Mode change to 2: selects already new when pll_reset first reads high.
    request(2);
    check("mc2_out_rst_n", out_rst_n, 0);
    check("mc2_pll_reset", pll_reset, 1);
    check_mode("mc2_load", 2);
    relock("mc2", RST + 1);
    check_mode("mc2_run", 2);

    // Random mode changes.
    for (int i = 0; i < 3; i++) begin
      m = int'($urandom_range(0, 3));
      request(m);
      check("rnd_out_rst_n", out_rst_n, 0);
      check_mode("rnd_load", m);
      relock("rnd", RST + 1);
      check_mode("rnd_run", m);
    end

    // Loss of lock in RUN, then a one-cycle glitch during STABLE.
    prev = int'(cur_mode);
    pll_lock = 1'b0;
    wait_until(P_OUT, 0, n);
    check("loss_out_rst_delay", n, SYNC_LAT + 1);
    check("loss_pll_reset", pll_reset, 1);
    check("loss_retry", retry_cnt, 0);
    check("loss_mode", cur_mode, prev);
    wait_until(P_RST, 0, n);
    check("loss_rst_width", n, RST);
    repeat (5) tick();
    pll_lock = 1'b1;
    g = int'($urandom_range(6, STABLE - 10));
    repeat (g) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_until(P_OUT, 1, n);
    check("glitch_release", n, STABLE + SYNC_LAT);
    check("glitch_retry", retry_cnt, 0);
    check("glitch_locked", locked, 1);

    // Lock loss and request on the same edge: the request wins.
    m = (int'(cur_mode) + 1 + int'($urandom_range(0, 2))) % 4;
    pll_lock = 1'b0;
    tick();
    tick();
    mode_req       = 2'(m);
    mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    check_mode("race_load", m);
    check("race_retry", retry_cnt, 0);
    check("race_out_rst_n", out_rst_n, 0);
    relock("race", RST + 1);

    // PLL never locks: three timeouts then FAULT. A request while not ready
    // is ignored.
    request(1);
    mode_req       = 2'd3;
    mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    check("ignored_req_mode", cur_mode, 1);
    wait_until(P_RST, 0, n);
    check("tmo_first_rst", n, RST);
    for (int k = 1; k <= RETRY; k++) begin
      wait_until(P_RETRY, k, n);
      check("tmo_wait_len", n, TMO);
      check("tmo_retry_cnt", retry_cnt, k);
      if (k < RETRY) begin
        check("tmo_pll_reset", pll_reset, 1);
        wait_until(P_RST, 0, n);
        check("tmo_retry_rst_width", n, RST);
      end
    end
    check("fault_fault", fault, 1);
    check("fault_pll_reset", pll_reset, 0);
    check("fault_out_rst_n", out_rst_n, 0);
    check("fault_ready", ready, 1);
    check("fault_locked", locked, 0);
    repeat (20) tick();
    check("fault_sticky", fault, 1);
    check("fault_retry_hold", retry_cnt, RETRY);
    request(0);
    check("fexit_fault", fault, 0);
    check("fexit_retry", retry_cnt, 0);
    check("fexit_pll_reset", pll_reset, 1);
    check_mode("fexit", 0);
    relock("fexit", RST + 1);

    // Asynchronous reset in WAIT_LOCK.
    request(3);
    wait_until(P_RST, 0, n);
    check("arst_pre_rst_width", n, RST + 1);
    repeat (5) tick();
    check("arst_pre_mode", cur_mode, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    tick();
    tick();
    rst_n = 1'b1;
    relock("arst", RST + 1);
    check_mode("arst_run", DEFM);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
